// File: rtl/dcache_refill_responder.sv
// Refill responder: queues line-refill reads and returns each line as BEATS tagged beats
// from a 1-cycle-latency word memory. Define CACHED_REGION_CHECK_EN to error out-of-region lines.
module dcache_refill_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WIDTH = 128,
  parameter int TID_WIDTH  = 4,
  parameter int REQ_DEPTH  = 4,
  parameter int MEM_AW     = 16,
  parameter logic [ADDR_WIDTH-1:0] CACHED_BASE = 64'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] CACHED_LEN  = 64'h4000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [TID_WIDTH-1:0]  req_tid_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic [TID_WIDTH-1:0]  resp_tid_o,
  output logic                  resp_last_o,
  output logic                  resp_error_o,
  output logic                  mem_req_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);
  localparam int BEATS  = LINE_WIDTH / DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(REQ_DEPTH);
  localparam int WOFF   = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] CAP  = 2'd2;
  localparam logic [1:0] SEND = 2'd3;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [TID_WIDTH-1:0]  tid;
  } req_t;

  req_t                  fifo_q [REQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        cnt_q;
  logic [1:0]            state_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  logic                  full, empty, push, pop, sending, last_beat, err_head;
  req_t                  head;
  logic [ADDR_WIDTH-1:0] line_addr;

  assign full      = (cnt_q == (PTR_W+1)'(REQ_DEPTH));
  assign empty     = (cnt_q == '0);
  assign head      = fifo_q[rd_ptr_q];
  assign line_addr = head.addr & LINE_MASK;
  assign sending   = (state_q == SEND);
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign push      = req_valid_i && req_ready_o;
  assign pop       = sending && resp_ready_i && last_beat;

`ifdef CACHED_REGION_CHECK_EN
  logic [ADDR_WIDTH:0] region_end;
  assign region_end = {1'b0, CACHED_BASE} + {1'b0, CACHED_LEN};
  assign err_head   = !((line_addr >= CACHED_BASE) && ({1'b0, line_addr} < region_end));
`else
  assign err_head   = 1'b0;
`endif

  // Storage needs no reset: entries are only read once cnt_q says they were written.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: req_addr_i, tid: req_tid_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!empty) begin
          beat_q <= '0;
          if (err_head) begin
            // Out-of-region line: a single zero-data error beat, no memory access.
            state_q <= SEND;
            err_q   <= 1'b1;
            data_q  <= '0;
            beat_q  <= BEAT_W'(BEATS - 1);
          end else begin
            state_q <= RD;
            err_q   <= 1'b0;
          end
        end
        RD:  state_q <= CAP;
        CAP: begin
          data_q  <= mem_rdata_i;
          state_q <= SEND;
        end
        SEND: if (resp_ready_i) begin
          if (last_beat) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
          end else begin
            beat_q  <= beat_q + 1'b1;
            state_q <= RD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = rst_ni && !full;
  assign resp_valid_o = sending;
  assign resp_data_o  = sending ? data_q : '0;
  assign resp_tid_o   = sending ? head.tid : '0;
  assign resp_last_o  = sending && last_beat;
  assign resp_error_o = sending && err_q;
  assign mem_req_o    = (state_q == RD);
  assign mem_addr_o   = mem_req_o ? MEM_AW'((line_addr >> WOFF) + ADDR_WIDTH'(beat_q)) : '0;
  assign busy_o       = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_dcache_refill_responder.sv
// Directed bench for dcache_refill_responder: vector table of single refills plus
// hand-written latency, full-FIFO, backpressure and mid-transfer reset sequences.
module tb_dcache_refill_responder;
`ifdef CACHED_REGION_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni, req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
  logic [63:0] req_addr_i, resp_data_o, mem_rdata_i;
  logic [3:0]  req_tid_i, resp_tid_o;
  logic        resp_last_o, resp_error_o, mem_req_o, busy_o;
  logic [15:0] mem_addr_o;

  int n_err = 0, n_chk = 0, cyc = 0;
  logic [15:0] mq[$];

  dcache_refill_responder dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_tid_i(req_tid_i), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o), .resp_tid_o(resp_tid_o),
    .resp_last_o(resp_last_o), .resp_error_o(resp_error_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o));

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [15:0] a);
    return {16'hDA7A, 32'h0, a};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata_i <= mem_req_o ? pat(mem_addr_o) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  always @(negedge clk) if (mem_req_o) mq.push_back(mem_addr_o);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_beat(input string name);
    int i;
    for (i = 0; i < 100 && !resp_valid_o; i++) tick();
    if (!resp_valid_o) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic push1(input logic [63:0] a, input logic [3:0] t);
    req_valid_i = 1'b1; req_addr_i = a; req_tid_i = t;
    tick();
    req_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  tid;
    logic [15:0] wa;
    bit          in_reg;
  } vec_t;
  vec_t vt[6];

  initial begin
    int t0, t1, nb, unstable;
    logic [69:0] snap;
    logic [4:0]  got[$];
    bit          acc;

    vt[0] = '{64'h8000_0010,          4'd3,  16'h0002, 1'b1};
    vt[1] = '{64'h8000_0000,          4'd1,  16'h0000, 1'b1};
    vt[2] = '{64'h8000_0028,          4'd5,  16'h0004, 1'b1};
    vt[3] = '{64'h8001_234F,          4'd9,  16'h2468, 1'b1};
    vt[4] = '{64'hFFFF_FFFF_FFFF_FFF8, 4'd15, 16'hFFFE, 1'b0};
    vt[5] = '{64'hC000_0000,          4'd7,  16'h0000, 1'b0};

    rst_ni = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b0;
    req_addr_i = '0; req_tid_i = '0;
    @(negedge clk); tick(); tick();
    check("rst_outputs",
          {resp_valid_o, resp_data_o, resp_tid_o, resp_last_o, resp_error_o, mem_req_o, mem_addr_o, busy_o, req_ready_o}, '0);
    rst_ni = 1'b1;
    tick();
    check("rst_ready", req_ready_o, 1);
    check("rst_busy", busy_o, 0);

    // Single-request latency: first beat 4 cycles after handshake, next 3 after that handshake.
    resp_ready_i = 1'b1;
    mq.delete();
    t0 = cyc;
    push1(64'h8000_0010, 4'd3);
    wait_beat("lat0");
    check("lat_first", cyc - t0, CHK ? 4 : 4);
    t1 = cyc;
    tick();
    wait_beat("lat1");
    check("lat_next", cyc - t1, 3);
    check("lat_last", resp_last_o, 1);
    tick();
    check("lat_idle", {resp_valid_o, busy_o}, 0);

    foreach (vt[k]) begin
      mq.delete();
      nb = (CHK && !vt[k].in_reg) ? 1 : 2;
      push1(vt[k].addr, vt[k].tid);
      for (int b = 0; b < nb; b++) begin
        wait_beat($sformatf("v%0d", k));
        check($sformatf("v%0d_b%0d_data", k, b), resp_data_o, (nb == 1) ? 64'd0 : pat(vt[k].wa + 16'(b)));
        check($sformatf("v%0d_b%0d_tid", k, b), resp_tid_o, vt[k].tid);
        check($sformatf("v%0d_b%0d_last", k, b), resp_last_o, b == nb - 1);
        check($sformatf("v%0d_b%0d_err", k, b), resp_error_o, nb == 1);
        tick();
      end
      tick();
      check($sformatf("v%0d_nreq", k), mq.size(), (nb == 1) ? 0 : 2);
      if (mq.size() == 2) begin
        check($sformatf("v%0d_wa0", k), mq[0], vt[k].wa);
        check($sformatf("v%0d_wa1", k), mq[1], vt[k].wa + 16'd1);
      end
    end

    // Fill the FIFO with no consumer, then drain in order while the 5th request waits.
    resp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1; req_addr_i = 64'h8000_0000 + 64'(16 * i); req_tid_i = 4'(i);
      check($sformatf("fill_ready%0d", i), req_ready_o, 1);
      tick();
    end
    req_addr_i = 64'h8000_0040; req_tid_i = 4'd4;
    check("full_ready", req_ready_o, 0);
    tick(); tick();
    check("full_ready_hold", req_ready_o, 0);
    resp_ready_i = 1'b1;
    acc = 1'b0;
    got.delete();
    for (int i = 0; i < 200 && got.size() < 10; i++) begin
      bit take;
      take = req_valid_i && req_ready_o;
      if (resp_valid_o) got.push_back({resp_tid_o, resp_last_o});
      tick();
      if (take) begin acc = 1'b1; req_valid_i = 1'b0; end
    end
    check("fifth_accepted", acc, 1);
    check("drain_count", got.size(), 10);
    foreach (got[k]) check($sformatf("drain%0d", k), got[k], {4'(k / 2), 1'(k % 2)});
    tick();

    // Backpressure on beat 0: everything stable, no extra memory read.
    resp_ready_i = 1'b0;
    mq.delete();
    push1(64'h8000_0100, 4'd6);
    wait_beat("bp");
    snap = {resp_valid_o, resp_data_o, resp_tid_o, resp_last_o};
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({resp_valid_o, resp_data_o, resp_tid_o, resp_last_o} !== snap) unstable++;
    end
    check("bp_unstable", unstable, 0);
    check("bp_snap", snap, {1'b1, pat(16'h0020), 4'd6, 1'b0});
    check("bp_nreq_hold", mq.size(), 1);
    resp_ready_i = 1'b1;
    tick();
    wait_beat("bp1");
    check("bp_data1", resp_data_o, pat(16'h0021));
    tick();
    check("bp_nreq_total", mq.size(), 2);

    // Reset while the head is in CAP with a second request queued.
    resp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 64'h8000_0200; req_tid_i = 4'd10;
    tick();
    req_addr_i = 64'h8000_0300; req_tid_i = 4'd11;
    tick();
    req_valid_i = 1'b0;
    check("mr_rd", mem_req_o, 1);
    tick();
    rst_ni = 1'b0;
    tick();
    check("mr_outputs",
          {resp_valid_o, resp_data_o, resp_tid_o, resp_last_o, resp_error_o, mem_req_o, mem_addr_o, busy_o}, '0);
    rst_ni = 1'b1;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid_o || mem_req_o || busy_o) unstable++;
    end
    check("mr_quiet", unstable, 0);
    check("mr_ready", req_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
